// File: rtl/looper_pkg.sv
// rtl/looper_pkg.sv - shared rename-stage constants and types
//
// Purpose: constants and types shared by the physical-register free list
//          and the branch checkpoint FIFO (fl_pos_t is the checkpoint format).
// Ports:   none (package).
package looper_pkg;

   localparam int PREG_NUM    = 64;
   localparam int PREG_W      = 6;
   localparam int PTR_W       = 7;
   localparam int ARCH_NUM    = 16;
   localparam int ISSUE_WIDTH = 4;

   typedef logic [PREG_W-1:0] preg_t;
   typedef logic [PTR_W-1:0]  fl_pos_t;

   // Reset content of list entry idx: pregs ARCH_NUM.. are free, the
   // tail entries beyond them are don't-care and cleared.
   function automatic preg_t reset_entry(input int idx);
      if (idx < PREG_NUM - ARCH_NUM)
         return preg_t'(idx + ARCH_NUM);
      else
         return '0;
   endfunction

endpackage

// File: rtl/preg_free_list_slot_rank4.sv
// rtl/preg_free_list_slot_rank4.sv - prefix popcount of a 4-bit slot mask
//
// Purpose: for each slot k, the number of set mask bits below k (rank),
//          plus the total number of set bits. Used to pack sparse slot
//          masks into consecutive free-list entries.
// Ports:
//   i_mask              4-bit slot mask, bit0 = oldest slot
//   o_rank0..o_rank3    set bits strictly below slot k
//   o_total             popcount of i_mask (0..4)
module slot_rank4 (
   input  logic [3:0] i_mask,
   output logic [1:0] o_rank0,
   output logic [1:0] o_rank1,
   output logic [1:0] o_rank2,
   output logic [1:0] o_rank3,
   output logic [2:0] o_total
);

   logic [2:0] w_c1;
   logic [2:0] w_c2;
   logic [2:0] w_c3;

   assign w_c1 = {2'b00, i_mask[0]};
   assign w_c2 = w_c1 + {2'b00, i_mask[1]};
   assign w_c3 = w_c2 + {2'b00, i_mask[2]};

   assign o_rank0 = 2'd0;
   assign o_rank1 = w_c1[1:0];
   assign o_rank2 = w_c2[1:0];
   assign o_rank3 = w_c3[1:0];
   assign o_total = w_c3 + {2'b00, i_mask[3]};

endmodule

// File: rtl/preg_free_list.sv
// rtl/preg_free_list.sv - 4-wide physical register free list with rollback
//
// Purpose: circular list of free physical registers. Grants up to 4 pregs
//          per cycle (all-or-nothing), accepts up to 4 released pregs per
//          cycle from commit, and restores the allocation pointer from a
//          branch checkpoint on mispredict.
// Ports:
//   i_clk, i_rst_n                      clock, async active-low reset
//   i_alloc_req[3:0]                    per-slot preg request, bit0 oldest
//   o_alloc_ok                          all requested slots granted (comb.)
//   o_alloc_preg0..3                    granted preg per slot (comb.)
//   i_cmt_free_vld[3:0]                 per-slot commit release valid
//   i_cmt_free_preg0..3                 released preg per slot
//   i_mis_pred, i_rcvr_pos              mispredict pulse, checkpoint to restore
//   o_cur_pos                           current allocation pointer
//   o_free_cnt                          number of free entries (0..64)
module preg_free_list
   import looper_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [3:0] i_alloc_req,
   output logic       o_alloc_ok,
   output logic [5:0] o_alloc_preg0,
   output logic [5:0] o_alloc_preg1,
   output logic [5:0] o_alloc_preg2,
   output logic [5:0] o_alloc_preg3,
   input  logic [3:0] i_cmt_free_vld,
   input  logic [5:0] i_cmt_free_preg0,
   input  logic [5:0] i_cmt_free_preg1,
   input  logic [5:0] i_cmt_free_preg2,
   input  logic [5:0] i_cmt_free_preg3,
   input  logic       i_mis_pred,
   input  logic [6:0] i_rcvr_pos,
   output logic [6:0] o_cur_pos,
   output logic [6:0] o_free_cnt
);

   preg_t   r_list [PREG_NUM];
   fl_pos_t r_alloc_ptr;
   fl_pos_t r_cmt_ptr;

   logic [1:0] w_arank0, w_arank1, w_arank2, w_arank3;
   logic [2:0] w_alloc_total;
   logic [1:0] w_rrank0, w_rrank1, w_rrank2, w_rrank3;
   logic [2:0] w_rel_total;

   fl_pos_t w_free_cnt;
   logic    w_alloc_ok;
   preg_t   w_abase, w_rbase;
   preg_t   w_aidx0, w_aidx1, w_aidx2, w_aidx3;
   preg_t   w_ridx0, w_ridx1, w_ridx2, w_ridx3;

   slot_rank4 u_alloc_rank (
      .i_mask  (i_alloc_req),
      .o_rank0 (w_arank0),
      .o_rank1 (w_arank1),
      .o_rank2 (w_arank2),
      .o_rank3 (w_arank3),
      .o_total (w_alloc_total)
   );

   slot_rank4 u_rel_rank (
      .i_mask  (i_cmt_free_vld),
      .o_rank0 (w_rrank0),
      .o_rank1 (w_rrank1),
      .o_rank2 (w_rrank2),
      .o_rank3 (w_rrank3),
      .o_total (w_rel_total)
   );

   // Pointer difference mod 128 distinguishes full (64) from empty (0).
   assign w_free_cnt = r_cmt_ptr - r_alloc_ptr;

   // Grant uses the pre-release count; releases become visible next cycle.
   assign w_alloc_ok = ({4'b0000, w_alloc_total} <= w_free_cnt) && !i_mis_pred;

   // 6-bit index arithmetic wraps entry 63 -> 0 on its own.
   assign w_abase = r_alloc_ptr[PREG_W-1:0];
   assign w_aidx0 = w_abase + {4'b0000, w_arank0};
   assign w_aidx1 = w_abase + {4'b0000, w_arank1};
   assign w_aidx2 = w_abase + {4'b0000, w_arank2};
   assign w_aidx3 = w_abase + {4'b0000, w_arank3};

   assign w_rbase = r_cmt_ptr[PREG_W-1:0];
   assign w_ridx0 = w_rbase + {4'b0000, w_rrank0};
   assign w_ridx1 = w_rbase + {4'b0000, w_rrank1};
   assign w_ridx2 = w_rbase + {4'b0000, w_rrank2};
   assign w_ridx3 = w_rbase + {4'b0000, w_rrank3};

   assign o_alloc_ok    = w_alloc_ok;
   assign o_alloc_preg0 = r_list[w_aidx0];
   assign o_alloc_preg1 = r_list[w_aidx1];
   assign o_alloc_preg2 = r_list[w_aidx2];
   assign o_alloc_preg3 = r_list[w_aidx3];
   assign o_cur_pos     = r_alloc_ptr;
   assign o_free_cnt    = w_free_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < PREG_NUM; i++) begin
            r_list[i] <= reset_entry(i);
         end
         r_alloc_ptr <= '0;
         r_cmt_ptr   <= fl_pos_t'(PREG_NUM - ARCH_NUM);
      end else begin
         if (i_mis_pred)
            r_alloc_ptr <= i_rcvr_pos;
         else if (w_alloc_ok)
            r_alloc_ptr <= r_alloc_ptr + {4'b0000, w_alloc_total};

         if (i_cmt_free_vld[0]) r_list[w_ridx0] <= i_cmt_free_preg0;
         if (i_cmt_free_vld[1]) r_list[w_ridx1] <= i_cmt_free_preg1;
         if (i_cmt_free_vld[2]) r_list[w_ridx2] <= i_cmt_free_preg2;
         if (i_cmt_free_vld[3]) r_list[w_ridx3] <= i_cmt_free_preg3;
         r_cmt_ptr <= r_cmt_ptr + {4'b0000, w_rel_total};
      end
   end

   // Releasing into a completely free list means a preg was freed twice.
   a_no_release_when_full: assert property (
      @(posedge i_clk) disable iff (!i_rst_n)
      !((w_free_cnt == fl_pos_t'(PREG_NUM)) && (w_rel_total != 3'd0)));

endmodule
